spi_nor_responder: RTL and testbench

- Byte-lane SPI NOR flash responder: the slave end of the APB-to-SPI NOR flash bridge's byte-wide SPI bus.
- Holds a small byte memory and decodes the standard command set: READ, PP, WREN, WRDI, RDSR, RDID.
- Runs entirely in the p_clk domain. It oversamples s_clk, s_css and s_mosi through synchronizers.
- Used as the flash model in bridge system benches and as a loopback target on FPGA.

---
 rtl/spi_nor_responder.sv | 181 ++++++++++++++++++
 tb/tb_spi_nor_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_nor_responder.sv
// Byte-lane SPI NOR flash responder running in the p_clk domain.
// Oversamples the SPI master's s_clk/s_css/s_mosi and serves READ, PP,
// WREN, WRDI, RDSR and RDID out of a small byte memory.
module spi_nor_responder #(
  parameter int          MEM_AW      = 10,
  parameter int          PAGE_SIZE   = 16,
  parameter int          PROG_CYCLES = 64,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4014
) (
  input  logic       p_clk,
  input  logic       p_reset,
  input  logic       s_clk,
  input  logic       s_css,
  input  logic [7:0] s_mosi,
  output logic [7:0] s_miso,
  output logic       s_miso_oe,
  output logic       wip,
  output logic       wel
);

  localparam int DEPTH = 2 ** MEM_AW;
  localparam int PW    = $clog2(PAGE_SIZE);
  localparam int CW    = $clog2(PROG_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, READ, PROG, STAT, ID, IGNORE
  } state_t;

  state_t state, state_n;

  logic       sclk_m, sclk_s, sclk_d;
  logic       css_m, css_s, css_d;
  logic [7:0] mosi_m, mosi_s;

  logic clk_rise, clk_fall, css_rise, css_fall;
  logic byte_in, byte_out, drive_n, prog_done;

  logic [1:0]        cnt;
  logic [MEM_AW-1:0] addr;
  logic              cmd_read;
  logic              written;
  logic [CW-1:0]     wip_cnt;

  // Array starts erased; contents survive p_reset.
  logic [7:0] mem [DEPTH] = '{default: 8'hFF};

  // Two-flop synchronizers plus a delayed copy for edge detection.
  // The css chain resets low so a select held low through reset never looks like a new fall.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      sclk_m <= 1'b0; sclk_s <= 1'b0; sclk_d <= 1'b0;
      css_m  <= 1'b0; css_s  <= 1'b0; css_d  <= 1'b0;
      mosi_m <= '0;   mosi_s <= '0;
    end else begin
      sclk_m <= s_clk;  sclk_s <= sclk_m; sclk_d <= sclk_s;
      css_m  <= s_css;  css_s  <= css_m;  css_d  <= css_s;
      mosi_m <= s_mosi; mosi_s <= mosi_m;
    end
  end

  assign clk_rise  = sclk_s & ~sclk_d;
  assign clk_fall  = ~sclk_s & sclk_d;
  assign css_rise  = css_s & ~css_d;
  assign css_fall  = ~css_s & css_d;
  assign byte_in   = clk_rise & ~css_rise & ~css_fall;
  assign byte_out  = clk_fall & ~css_rise & ~css_fall;
  assign prog_done = css_rise & (state == PROG) & wel & written;
  assign wip       = (wip_cnt != '0);

  // State register.
  always_ff @(posedge p_clk) begin
    if (p_reset) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state decode: css edges take priority over any s_clk edge.
  always_comb begin
    state_n = state;
    if (css_rise) begin
      state_n = IDLE;
    end else if (css_fall) begin
      state_n = CMD;
    end else if (clk_rise) begin
      case (state)
        CMD: begin
          if (wip) begin
            state_n = (mosi_s == 8'h05) ? STAT : IGNORE;
          end else begin
            case (mosi_s)
              8'h03, 8'h02: state_n = ADDR;
              8'h05:        state_n = STAT;
              8'h9F:        state_n = ID;
              default:      state_n = IGNORE;
            endcase
          end
        end
        ADDR: if (cnt == 2'd2) state_n = cmd_read ? READ : PROG;
        default: ;
      endcase
    end
  end

  assign drive_n = (state_n == READ) || (state_n == STAT) || (state_n == ID);

  // Program timer: loaded when a page program closes, counts down to idle.
  always_ff @(posedge p_clk) begin
    if (p_reset)           wip_cnt <= '0;
    else if (prog_done)    wip_cnt <= CW'(PROG_CYCLES);
    else if (wip_cnt != '0) wip_cnt <= wip_cnt - CW'(1);
  end

  // Page-program writes into the array.
  always_ff @(posedge p_clk) begin
    if (byte_in && (state == PROG) && wel) mem[addr] <= mosi_s;
  end

  // Command/address capture, status latch and read-data launch.
  // Only the low MEM_AW bits of the 24-bit address are kept; in READ, cnt
  // doubles as a first-byte flag so the first fall serves mem[addr] unadvanced.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      cnt       <= '0;
      addr      <= '0;
      cmd_read  <= 1'b0;
      written   <= 1'b0;
      wel       <= 1'b0;
      s_miso    <= '0;
      s_miso_oe <= 1'b0;
    end else begin
      if (prog_done) wel <= 1'b0;
      if (css_fall) begin
        cnt     <= '0;
        written <= 1'b0;
      end else if (byte_in) begin
        case (state)
          CMD: begin
            cmd_read <= (mosi_s == 8'h03);
            cnt      <= '0;
            if (!wip && mosi_s == 8'h06) wel <= 1'b1;
            if (!wip && mosi_s == 8'h04) wel <= 1'b0;
          end
          ADDR: begin
            addr <= MEM_AW'({addr, mosi_s});
            cnt  <= (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;
          end
          PROG: begin
            addr[PW-1:0] <= addr[PW-1:0] + PW'(1);
            if (wel) written <= 1'b1;
          end
          default: ;
        endcase
      end else if (byte_out) begin
        case (state)
          READ: begin
            if (cnt == 2'd0) begin
              s_miso <= mem[addr];
              cnt    <= 2'd1;
            end else begin
              s_miso <= mem[addr + MEM_AW'(1)];
              addr   <= addr + MEM_AW'(1);
            end
          end
          STAT: s_miso <= {6'b0, wel, wip};
          ID: begin
            case (cnt)
              2'd0:    s_miso <= JEDEC_ID[23:16];
              2'd1:    s_miso <= JEDEC_ID[15:8];
              2'd2:    s_miso <= JEDEC_ID[7:0];
              default: s_miso <= 8'hFF;
            endcase
            if (cnt != 2'd3) cnt <= cnt + 2'd1;
          end
          default: ;
        endcase
      end
      s_miso_oe <= drive_n;
      if (!drive_n) s_miso <= '0;
    end
  end

endmodule

// File: tb/tb_spi_nor_responder.sv
// Randomized bench for spi_nor_responder against a byte-array flash model.
module tb_spi_nor_responder;

  localparam int          AW    = 10;
  localparam int          DEPTH = 1024;
  localparam int          PAGE  = 16;
  localparam int          PROGC = 64;
  localparam int          PH    = 4;
  localparam logic [23:0] JID   = 24'hEF4014;

  logic       p_clk = 1'b0;
  logic       p_reset = 1'b1;
  logic       s_clk = 1'b0;
  logic       s_css = 1'b1;
  logic [7:0] s_mosi = 8'h00;
  logic [7:0] s_miso;
  logic       s_miso_oe;
  logic       wip;
  logic       wel;

  spi_nor_responder #(
    .MEM_AW(AW), .PAGE_SIZE(PAGE), .PROG_CYCLES(PROGC), .JEDEC_ID(JID)
  ) dut (
    .p_clk(p_clk), .p_reset(p_reset), .s_clk(s_clk), .s_css(s_css),
    .s_mosi(s_mosi), .s_miso(s_miso), .s_miso_oe(s_miso_oe),
    .wip(wip), .wel(wel)
  );

  always #5 p_clk = ~p_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem_m [DEPTH];
  bit         wel_m;
  logic [7:0] tx [40];
  logic [7:0] rx [40];
  logic       oe_s [40];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Flash rule: bytes of a page program land at successive offsets, wrapping in the page.
  function automatic int unsigned page_idx(input int unsigned a, input int k);
    int unsigned base;
    base = a % DEPTH;
    return (base - base % PAGE) + ((base % PAGE) + k) % PAGE;
  endfunction

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r, output logic o);
    s_mosi = b;
    repeat (PH) @(negedge p_clk);
    r = s_miso;
    o = s_miso_oe;
    s_clk = 1'b1;
    repeat (PH) @(negedge p_clk);
    s_clk = 1'b0;
  endtask

  task automatic spi_txn(input int n);
    repeat (PH) @(negedge p_clk);
    s_css = 1'b0;
    repeat (PH) @(negedge p_clk);
    for (int i = 0; i < n; i++) spi_byte(tx[i], rx[i], oe_s[i]);
    repeat (PH) @(negedge p_clk);
    s_css = 1'b1;
  endtask

  task automatic wip_pulse(output int len);
    int t;
    t = 0;
    len = 0;
    while (!wip && t < 20) begin @(negedge p_clk); t++; end
    while (wip && len < 500) begin @(negedge p_clk); len++; end
  endtask

  task automatic wren();
    tx[0] = 8'h06;
    spi_txn(1);
    wel_m = 1'b1;
    repeat (PH) @(negedge p_clk);
    check("wren_wel", {31'd0, wel}, {31'd0, wel_m});
  endtask

  // Data bytes must already sit in tx[4..4+n-1].
  task automatic do_pp(input logic [23:0] a, input int n);
    int len;
    bit seen;
    tx[0] = 8'h02; tx[1] = a[23:16]; tx[2] = a[15:8]; tx[3] = a[7:0];
    spi_txn(4 + n);
    if (wel_m) begin
      for (int k = 0; k < n; k++) mem_m[page_idx(a, k)] = tx[4 + k];
      wel_m = 1'b0;
      wip_pulse(len);
      check("pp_wip_len", len, PROGC);
    end else begin
      seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge p_clk);
        if (wip) seen = 1'b1;
      end
      check("pp_no_wip", {31'd0, seen}, 32'd0);
    end
    check("pp_wel", {31'd0, wel}, {31'd0, wel_m});
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    tx[0] = 8'h03; tx[1] = a[23:16]; tx[2] = a[15:8]; tx[3] = a[7:0];
    for (int k = 0; k < n; k++) tx[4 + k] = 8'h00;
    spi_txn(4 + n);
    check("rd_oe_addr", {31'd0, oe_s[3]}, 32'd0);
    for (int k = 0; k < n; k++) begin
      check("rd_data", {24'd0, rx[4 + k]}, {24'd0, mem_m[(int'(a) + k) % DEPTH]});
      check("rd_oe", {31'd0, oe_s[4 + k]}, 32'd1);
    end
    repeat (PH) @(negedge p_clk);
    check("rd_oe_end", {31'd0, s_miso_oe}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  r, v;
    logic        o;
    logic [23:0] a;
    int          n;
    bit          mono, saw0;
    int          zeros;

    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
    wel_m = 1'b0;

    repeat (4) @(negedge p_clk);
    check("rst_miso", {24'd0, s_miso}, 32'd0);
    check("rst_oe", {31'd0, s_miso_oe}, 32'd0);
    check("rst_wip", {31'd0, wip}, 32'd0);
    check("rst_wel", {31'd0, wel}, 32'd0);
    p_reset = 1'b0;

    // Basic program then read back.
    wren();
    tx[4] = 8'hA5; tx[5] = 8'h5A; tx[6] = 8'hC3; tx[7] = 8'h3C;
    do_pp(24'h000010, 4);
    do_read(24'h000010, 4);

    // Program without write enable is discarded.
    tx[4] = 8'h11;
    do_pp(24'h000020, 1);
    do_read(24'h000020, 1);

    // Page wrap.
    wren();
    tx[4] = 8'h01; tx[5] = 8'h02; tx[6] = 8'h03; tx[7] = 8'h04;
    do_pp(24'h00001E, 4);
    do_read(24'h00000E, 20);

    // Status polling across a program, with RDID refused while busy.
    wren();
    tx[0] = 8'h05; tx[1] = 8'h00;
    spi_txn(2);
    check("rdsr_wel", {24'd0, rx[1]}, 32'h02);
    tx[0] = 8'h02; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h40; tx[4] = 8'h77;
    spi_txn(5);
    mem_m[16'h040] = 8'h77;
    wel_m = 1'b0;
    tx[0] = 8'h9F; tx[1] = 8'h00;
    spi_txn(2);
    check("rdid_busy_oe", {31'd0, oe_s[1]}, 32'd0);
    check("rdid_busy_miso", {24'd0, rx[1]}, 32'd0);
    mono = 1'b1; saw0 = 1'b0; zeros = 0; v = 8'hEE;
    for (int p = 0; p < 30 && zeros < 2; p++) begin
      tx[0] = 8'h05; tx[1] = 8'h00;
      spi_txn(2);
      v = rx[1];
      if (p == 0) check("rdsr_busy", {24'd0, v}, 32'h01);
      if (saw0 && v != 8'h00) mono = 1'b0;
      if (v != 8'h00 && v != 8'h01) mono = 1'b0;
      if (v == 8'h00) begin saw0 = 1'b1; zeros++; end
    end
    check("rdsr_done", {24'd0, v}, 32'h00);
    check("rdsr_mono", {31'd0, mono}, 32'd1);
    do_read(24'h000040, 1);

    // JEDEC ID.
    tx[0] = 8'h9F;
    for (int k = 1; k < 5; k++) tx[k] = 8'h00;
    spi_txn(5);
    check("rdid_b0", {24'd0, rx[1]}, {24'd0, JID[23:16]});
    check("rdid_b1", {24'd0, rx[2]}, {24'd0, JID[15:8]});
    check("rdid_b2", {24'd0, rx[3]}, {24'd0, JID[7:0]});
    check("rdid_b3", {24'd0, rx[4]}, 32'hFF);
    check("rdid_oe", {31'd0, oe_s[1]}, 32'd1);

    // Randomized programs and reads.
    for (int it = 0; it < 8; it++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 3) != 0) wren();
      for (int k = 0; k < n; k++) tx[4 + k] = 8'($urandom);
      do_pp(a, n);
      do_read(24'({a[23:4], 4'h0}), 16);
      do_read(24'($urandom), 6);
    end

    // Address wrap at the top of memory, upper address bits ignored.
    do_read(24'hFFFFFE, 4);

    // Reset in the middle of a READ.
    repeat (PH) @(negedge p_clk);
    s_css = 1'b0;
    repeat (PH) @(negedge p_clk);
    spi_byte(8'h03, r, o);
    spi_byte(8'h00, r, o);
    spi_byte(8'h00, r, o);
    spi_byte(8'h10, r, o);
    spi_byte(8'h00, r, o);
    check("rst_rd_pre", {24'd0, r}, {24'd0, mem_m[16'h010]});
    spi_byte(8'h00, r, o);
    p_reset = 1'b1;
    repeat (2) @(negedge p_clk);
    p_reset = 1'b0;
    wel_m = 1'b0;
    repeat (2) @(negedge p_clk);
    check("rst_mid_miso", {24'd0, s_miso}, 32'd0);
    check("rst_mid_oe", {31'd0, s_miso_oe}, 32'd0);
    check("rst_mid_wel", {31'd0, wel}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      spi_byte(8'h00, r, o);
      check("rst_quiet_miso", {24'd0, r}, 32'd0);
      check("rst_quiet_oe", {31'd0, o}, 32'd0);
    end
    repeat (PH) @(negedge p_clk);
    s_css = 1'b1;
    do_read(24'h000010, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
